// File: rtl/multipath_channel_if.sv
// Sample-stream bus of the multipath channel model: sample enable, input sample
// and the registered channel output.
interface multipath_channel_if #(
    parameter int DW = 18,
    parameter int OW = 28
);
    logic                 en;
    logic signed [DW-1:0] Din;
    logic signed [OW-1:0] OUT;

    modport master (output en, Din, input OUT);
    modport slave  (input en, Din, output OUT);
endinterface

// File: rtl/multipath_channel.sv
// Four-path multipath channel: y[n] = G0*x[n] + G1*x[n-D1] + G2*x[n-D2] + G3*x[n-D3],
// full-precision products summed exactly into a registered OW-bit output.
module multipath_channel #(
    parameter int DW = 18,
    parameter int GW = 8,
    parameter int OW = 28,
    parameter int D1 = 2,
    parameter int D2 = 5,
    parameter int D3 = 9,
    parameter int G0 = 127,
    parameter int G1 = -64,
    parameter int G2 = 32,
    parameter int G3 = 16
) (
    input  logic               clk,
    input  logic               rst,
    multipath_channel_if.slave bus
);
    localparam int PW = DW + GW;

    localparam logic signed [GW-1:0] G0_V = GW'(G0);
    localparam logic signed [GW-1:0] G1_V = GW'(G1);
    localparam logic signed [GW-1:0] G2_V = GW'(G2);
    localparam logic signed [GW-1:0] G3_V = GW'(G3);

    // Signed DW x GW product at full precision, sign-extended to the output width.
    function automatic logic signed [OW-1:0] tap(input logic signed [DW-1:0] x,
                                                 input logic signed [GW-1:0] g);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ge;
        logic signed [PW-1:0] p;
        xe = PW'(x);
        ge = PW'(g);
        p  = xe * ge;
        return OW'(p);
    endfunction

    logic signed [DW-1:0] dly_q [1:D3];
    logic signed [DW-1:0] dly_d [1:D3];
    logic signed [OW-1:0] out_q;
    logic signed [OW-1:0] out_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        dly_d = dly_q;
        out_d = out_q;
        if (bus.en) begin
            dly_d[1] = bus.Din;
            for (int k = 2; k <= D3; k++) begin
                dly_d[k] = dly_q[k-1];
            end
            // Taps read the pre-shift registers, so dly_q[k] is x[n-k] here.
            out_d = tap(bus.Din,   G0_V) + tap(dly_q[D1], G1_V)
                  + tap(dly_q[D2], G2_V) + tap(dly_q[D3], G3_V);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the delay line is reset on purpose; a mid-stream reset must discard all echo history.
            for (int k = 1; k <= D3; k++) begin
                dly_q[k] <= '0;
            end
            out_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            dly_q <= dly_d;
            out_q <= out_d;
        end
    end

    assign bus.OUT = out_q;

endmodule

// File: tb/tb_multipath_channel.sv
// Directed and model-based checks of the four-path multipath channel.
module tb_multipath_channel;
    localparam int DW = 18;
    localparam int OW = 28;
    localparam int D1 = 2;
    localparam int D2 = 5;
    localparam int D3 = 9;
    localparam int G0 = 127;
    localparam int G1 = -64;
    localparam int G2 = 32;
    localparam int G3 = 16;
    localparam int NRAND = 2048;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    multipath_channel_if #(.DW(DW), .OW(OW)) bus ();

    multipath_channel #(
        .DW(DW), .GW(8), .OW(OW),
        .D1(D1), .D2(D2), .D3(D3),
        .G0(G0), .G1(G1), .G2(G2), .G3(G3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic cycle(input logic e, input int d);
        @(negedge clk);
        bus.en  = e;
        bus.Din = DW'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        bus.en  = 1'b0;
        bus.Din = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic signed [OW-1:0] exp_v;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5000);
            vectors++;
            if (bus.OUT !== '0) begin
                $display("FAIL reset_hold[%0d]: got %0d, required 0", i, bus.OUT);
                miscompares++;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 5000);
        exp_v = 635000;
        vectors++;
        if (bus.OUT !== exp_v) begin
            $display("FAIL reset_release: got %0d, required %0d", bus.OUT, exp_v);
            miscompares++;
        end
    endtask

    task automatic test_impulse();
        int exp_tab [11] = '{127000, 0, -64000, 0, 0, 32000, 0, 0, 0, 16000, 0};
        logic signed [OW-1:0] exp_v;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, (i == 0) ? 1000 : 0);
            exp_v = OW'(exp_tab[i]);
            vectors++;
            if (bus.OUT !== exp_v) begin
                $display("FAIL impulse[%0d]: got %0d, required %0d", i, bus.OUT, exp_v);
                miscompares++;
            end
        end
    endtask

    task automatic test_extremes();
        logic signed [OW-1:0] exp_v;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, -131072);
            if (i == 0 || i == 11) begin
                exp_v = (i == 0) ? OW'(-16646144) : OW'(-14548992);
                vectors++;
                if (bus.OUT !== exp_v) begin
                    $display("FAIL extreme_neg[%0d]: got %0d, required %0d", i, bus.OUT, exp_v);
                    miscompares++;
                end
            end
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 131071);
            if (i == 0 || i == 11) begin
                exp_v = (i == 0) ? OW'(18743169) : OW'(14548881);
                vectors++;
                if (bus.OUT !== exp_v) begin
                    $display("FAIL extreme_pos[%0d]: got %0d, required %0d", i, bus.OUT, exp_v);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_enable_gating();
        int exp_head [2] = '{127000, 0};
        int exp_tail [9] = '{-64000, 0, 0, 32000, 0, 0, 0, 16000, 0};
        logic signed [OW-1:0] exp_v;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, (i == 0) ? 1000 : 0);
            exp_v = OW'(exp_head[i]);
            vectors++;
            if (bus.OUT !== exp_v) begin
                $display("FAIL gate_head[%0d]: got %0d, required %0d", i, bus.OUT, exp_v);
                miscompares++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 7777);
            vectors++;
            if (bus.OUT !== '0) begin
                $display("FAIL gate_hold[%0d]: got %0d, required 0", i, bus.OUT);
                miscompares++;
            end
        end
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 0);
            exp_v = OW'(exp_tail[i]);
            vectors++;
            if (bus.OUT !== exp_v) begin
                $display("FAIL gate_tail[%0d]: got %0d, required %0d", i, bus.OUT, exp_v);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic signed [OW-1:0] exp_v;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, (i == 0) ? 1000 : 0);
        end
        exp_v = OW'(-64000);
        vectors++;
        if (bus.OUT !== exp_v) begin
            $display("FAIL midrst_before: got %0d, required %0d", bus.OUT, exp_v);
            miscompares++;
        end
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.OUT !== '0) begin
            $display("FAIL midrst_async: got %0d, required 0", bus.OUT);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 0);
            vectors++;
            if (bus.OUT !== '0) begin
                $display("FAIL midrst_tail[%0d]: got %0d, required 0", i, bus.OUT);
                miscompares++;
            end
        end
    endtask

    task automatic test_random();
        int                   xs [NRAND];
        int                   n;
        int                   guard;
        longint               acc;
        logic signed [OW-1:0] exp_v;
        logic signed [DW-1:0] r;
        logic                 e;
        do_reset();
        n     = 0;
        guard = 0;
        exp_v = '0;
        while (n < NRAND && guard < 4 * NRAND) begin
            guard++;
            e = ($urandom_range(3) != 0);
            r = DW'($urandom);
            cycle(e, int'(r));
            if (e) begin
                xs[n] = int'(r);
                acc = longint'(G0) * xs[n];
                if (n >= D1) acc += longint'(G1) * xs[n-D1];
                if (n >= D2) acc += longint'(G2) * xs[n-D2];
                if (n >= D3) acc += longint'(G3) * xs[n-D3];
                exp_v = OW'(acc);
                n++;
            end
            vectors++;
            if (bus.OUT !== exp_v) begin
                $display("FAIL random[%0d]: got %0d, required %0d", n, bus.OUT, exp_v);
                miscompares++;
            end
        end
        vectors++;
        if (n != NRAND) begin
            $display("FAIL random_count: got %0d samples, required %0d", n, NRAND);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        bus.en      = 1'b0;
        bus.Din     = '0;
        test_reset();
        test_impulse();
        test_extremes();
        test_enable_gating();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
